dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the byte-wide data memory. Requester A is the CPU MEM stage; requester B is the loader/debug port. The block serialises both onto the single memory port, and holds `mem_read_o`/`mem_write_o` for a configurable number of cycles. It returns a one-cycle completion pulse with read data to the winning requester.

## Interface
- `MEM_DEPTH`, 32: number of addressable memory entries; legal addresses are 0..MEM_DEPTH-1.
- `ACCESS_CYCLES`, 1: cycles the memory strobes are held per access; legal range 1..15.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `a_req_i`, `b_req_i` in 1: access request; held until the matching grant.
- `a_we_i`, `b_we_i` in 1: 1 = write, 0 = read.
- `a_addr_i`, `b_addr_i` in 32: address.
- `a_wdata_i`, `b_wdata_i` in 32: write data; only [7:0] is stored by the memory.
- `a_gnt_o`, `b_gnt_o` out 1: one-cycle grant pulse.
- `a_done_o`, `b_done_o` out 1: one-cycle completion pulse.
- `a_err_o`, `b_err_o` out 1: valid with done; address out of range.
- `rdata_o` out 32: read data, valid with either done.
- `mem_read_o`, `mem_write_o` out 1: memory strobes.
- `mem_addr_o`, `mem_wdata_o` out 32: latched address and write data.
- `mem_rdata_i` in 32: memory read data.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: if any `*_req_i` is high at the edge, latch we/addr/wdata of the winner, set owner, go to ACCESS (legal address) or RESP with error (address >= MEM_DEPTH).
  - ACCESS: the strobe for the latched op is high; a down-counter loads ACCESS_CYCLES-1. Stay while counter != 0. On the edge with counter == 0, capture `mem_rdata_i` (read) and go to RESP.
  - RESP: owner's done pulses high for one cycle; error path also raises that owner's err. Always returns to IDLE.
- Arbitration:
  - Round-robin; a 1-bit pointer names the preferred requester.
  - Reset value prefers A.
  - After any grant, the pointer moves to the other requester.
  - A lone requester always wins regardless of the pointer.
- Grant:
  - `*_gnt_o` is registered and is high during the first cycle after the IDLE→ACCESS/RESP edge.
  - A requester drops req in its grant cycle.
  - If req is still high in IDLE, it is a new request.
- Strobes are mutually exclusive; both are zero outside ACCESS.
- `mem_addr_o`/`mem_wdata_o` hold their latched values until the next grant.
- `rdata_o`:
  - Holds the last captured read value.
  - Writes leave it unchanged.
  - An error read forces it to 0.
- Requests arriving while busy wait; there is no queueing beyond the req level.
- A requester dropping req before grant is never served.

## Timing
- Reset (async assert, sync-safe deassert by caller) puts the block in this state immediately:
  - state IDLE, pointer = A.
  - All outputs 0: `mem_addr_o`, `mem_wdata_o`, `rdata_o`, all gnt/done/err, strobes, `busy_o`.
- Reset mid-ACCESS aborts the access immediately; the requester receives no done.
- Legal access with req high at edge 0:
  - Grant in cycle 1.
  - Strobes in cycles 1..ACCESS_CYCLES.
  - Done in cycle ACCESS_CYCLES+1.
  - Next grant no earlier than cycle ACCESS_CYCLES+3.
- Illegal address: grant and err/done in the same cycle 1; no strobe ever asserts.
- Throughput: one access per ACCESS_CYCLES+2 cycles.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined:
  - A always wins simultaneous requests.
  - The pointer logic is removed.
  - B can starve.
- Undefined: round-robin as above.

## Test plan
- Reset during ACCESS with a read in flight:
  - All outputs are 0 immediately after reset assertion.
  - After release, a new A read at addr 4 completes normally.
- A write, addr 3, wdata 0x5A, ACCESS_CYCLES=1:
  - `a_gnt_o` in cycle 1.
  - `mem_write_o` in cycle 1 only.
  - `a_done_o` in cycle 2.
  - A following A read of addr 3 returns `rdata_o`=0x5A.
- Both requesters high continuously from reset, without the macro:
  - Grants go A, B, A, B.
  - With `DMEM_ARB_FIXED_PRIO_EN`: A, A, A.
- ACCESS_CYCLES=3, B read of addr 7:
  - `mem_read_o` high for exactly 3 cycles.
  - `b_done_o` 4 cycles after the request edge.
  - `busy_o` high through RESP.
- A read of addr 40 with MEM_DEPTH=32:
  - `a_gnt_o`, `a_done_o` and `a_err_o` all high in cycle 1.
  - `rdata_o`=0.
  - No strobe.
- B requests during A's ACCESS, then holds req:
  - B is granted in the cycle after A's RESP→IDLE edge.
  - `a_done_o` and `b_gnt_o` never overlap.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates two requesters (A = CPU MEM stage, B = loader/debug port) onto
//   the single byte-wide data memory port. Each access holds its strobe for
//   ACCESS_CYCLES cycles. The owner then gets a one-cycle done pulse with the
//   read data. An out-of-range address skips the memory and answers at once
//   with done+err.
//
//   Optional build macro: DMEM_ARB_FIXED_PRIO_EN
//     defined   -> A always wins simultaneous requests (B can starve)
//     undefined -> round-robin between A and B
//
//   Ports
//     clk_i, rst_i             clock (rising edge), async active-low reset
//     a_/b_req_i, we_i         request level and direction (1 = write)
//     a_/b_addr_i, wdata_i     address and write data of each requester
//     a_/b_gnt_o               one-cycle grant pulse
//     a_/b_done_o, err_o       one-cycle completion pulse, error with done
//     rdata_o                  last captured read data
//     mem_read_o, mem_write_o  memory strobes
//     mem_addr_o, mem_wdata_o  latched address / write data
//     mem_rdata_i              memory read data
//     busy_o                   high whenever the sequencer is not idle
module dmem_arbiter #(
   parameter int unsigned MEM_DEPTH     = 32,
   parameter int unsigned ACCESS_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        a_req_i,
   input  logic        a_we_i,
   input  logic [31:0] a_addr_i,
   input  logic [31:0] a_wdata_i,
   input  logic        b_req_i,
   input  logic        b_we_i,
   input  logic [31:0] b_addr_i,
   input  logic [31:0] b_wdata_i,
   output logic        a_gnt_o,
   output logic        b_gnt_o,
   output logic        a_done_o,
   output logic        b_done_o,
   output logic        a_err_o,
   output logic        b_err_o,
   output logic [31:0] rdata_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

   localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

   stateT       state;
   logic [3:0]  accessCnt;
   logic        ownerB;      // 1 when B owns the access in flight
   logic        opWrite;

   logic        pickB;
   logic        selWe;
   logic [31:0] selAddr;
   logic [31:0] selWdata;
   logic        selIllegal;

`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic        ptrB;        // preferred requester on a tie: 0 = A, 1 = B
`endif

   // Winner selection: a lone requester always wins; a tie goes to the
   // preferred side.
   always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      pickB = b_req_i & ~a_req_i;
`else
      pickB = b_req_i & (~a_req_i | ptrB);
`endif
      selWe      = pickB ? b_we_i    : a_we_i;
      selAddr    = pickB ? b_addr_i  : a_addr_i;
      selWdata   = pickB ? b_wdata_i : a_wdata_i;
      selIllegal = (selAddr >= 32'(MEM_DEPTH));
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         accessCnt   <= '0;
         ownerB      <= 1'b0;
         opWrite     <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         ptrB        <= 1'b0;
`endif
         a_gnt_o     <= 1'b0;
         b_gnt_o     <= 1'b0;
         a_done_o    <= 1'b0;
         b_done_o    <= 1'b0;
         a_err_o     <= 1'b0;
         b_err_o     <= 1'b0;
         rdata_o     <= '0;
         mem_read_o  <= 1'b0;
         mem_write_o <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         busy_o      <= 1'b0;
      end else begin
         // grant/done/err are single-cycle pulses
         a_gnt_o  <= 1'b0;
         b_gnt_o  <= 1'b0;
         a_done_o <= 1'b0;
         b_done_o <= 1'b0;
         a_err_o  <= 1'b0;
         b_err_o  <= 1'b0;

         unique case (state)
            IDLE: begin
               if (a_req_i || b_req_i) begin
                  ownerB      <= pickB;
                  opWrite     <= selWe;
                  mem_addr_o  <= selAddr;
                  mem_wdata_o <= selWdata;
                  a_gnt_o     <= ~pickB;
                  b_gnt_o     <= pickB;
                  busy_o      <= 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                  ptrB        <= ~pickB;
`endif
                  if (selIllegal) begin
                     // out-of-range: answer in the grant cycle, never touch memory
                     state    <= RESP;
                     a_done_o <= ~pickB;
                     b_done_o <= pickB;
                     a_err_o  <= ~pickB;
                     b_err_o  <= pickB;
                     if (!selWe) begin
                        rdata_o <= '0;
                     end
                  end else begin
                     state       <= ACCESS;
                     accessCnt   <= CntLoad;
                     mem_read_o  <= ~selWe;
                     mem_write_o <= selWe;
                  end
               end
            end
            ACCESS: begin
               if (accessCnt != 4'd0) begin
                  accessCnt <= accessCnt - 4'd1;
               end else begin
                  state       <= RESP;
                  mem_read_o  <= 1'b0;
                  mem_write_o <= 1'b0;
                  a_done_o    <= ~ownerB;
                  b_done_o    <= ownerB;
                  if (!opWrite) begin
                     rdata_o <= mem_rdata_i;
                  end
               end
            end
            RESP: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
